// File: rtl/coord_mem_arbiter_if.sv
// Bus bundle between the coordinate loader, the pathfinding reader,
// the node-coordinate RAM and the coord_mem_arbiter.
// slave  = arbiter side, master = the surrounding loader/reader/RAM side.
interface coord_mem_arbiter_if #(
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 8
);
    logic                   ld_valid;
    logic [COORD_W-1:0]     ld_x;
    logic [COORD_W-1:0]     ld_y;
    logic                   ld_finish;
    logic                   ld_ready;

    logic                   rd_req;
    logic [ADDR_W-1:0]      rd_idx;
    logic                   rd_gnt;
    logic                   rd_valid;
    logic [COORD_W-1:0]     rd_x;
    logic [COORD_W-1:0]     rd_y;
    logic                   rd_err;

    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [2*COORD_W-1:0]   mem_wdata;
    logic [2*COORD_W-1:0]   mem_rdata;

    logic [ADDR_W:0]        node_count;
    logic                   load_done;
    logic                   overflow;

    modport slave (
        input  ld_valid, ld_x, ld_y, ld_finish, rd_req, rd_idx, mem_rdata,
        output ld_ready, rd_gnt, rd_valid, rd_x, rd_y, rd_err,
               mem_en, mem_we, mem_addr, mem_wdata, node_count, load_done, overflow
    );

    modport master (
        output ld_valid, ld_x, ld_y, ld_finish, rd_req, rd_idx, mem_rdata,
        input  ld_ready, rd_gnt, rd_valid, rd_x, rd_y, rd_err,
               mem_en, mem_we, mem_addr, mem_wdata, node_count, load_done, overflow
    );
endinterface

// File: rtl/coord_mem_arbiter.sv
// Arbitrates one single-port coordinate RAM between an initial loader
// (writes nodes sequentially from address 0) and a pathfinding reader.
// Contested cycles alternate via a 1-bit round-robin pointer. Reads of
// unloaded indices return an error response without touching the RAM.
module coord_mem_arbiter #(
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    coord_mem_arbiter_if.slave   bus
);
    typedef enum logic {LOADING = 1'b0, SEALED = 1'b1} state_t;

    state_t               state;
    state_t               state_next;
    logic                 ptr;          // 0: loader wins next contest, 1: reader
    logic [ADDR_W:0]      count;
    logic                 ovf;
    logic                 vld_p1;       // read response pending on the RAM output
    logic                 hit_p1;       // that response carries RAM data

    logic                 full;
    logic                 ld_elig;
    logic                 rd_elig;
    logic                 contested;
    logic                 gnt_ld;
    logic                 gnt_rd;
    logic                 rd_hit;
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [2*COORD_W-1:0] mem_wdata;

    // State register: LOADING until ld_finish, then SEALED until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOADING;
        else       state <= state_next;
    end

    // Next state, eligibility, grant selection and RAM port drive.
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        // count never exceeds 2**ADDR_W, so its top bit alone marks full.
        full      = count[ADDR_W];
        ld_elig   = !reset && (state == LOADING) && bus.ld_valid && !full;
        rd_elig   = !reset && bus.rd_req;
        contested = ld_elig && rd_elig;
        gnt_ld    = ld_elig && (!rd_elig || !ptr);
        gnt_rd    = rd_elig && (!ld_elig || ptr);
        rd_hit    = ({1'b0, bus.rd_idx} < count);

        if (state == LOADING && bus.ld_finish) state_next = SEALED;

        if (gnt_ld) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = count[ADDR_W-1:0];
            mem_wdata = {bus.ld_x, bus.ld_y};
        end else if (gnt_rd && rd_hit) begin
            mem_en   = 1'b1;
            mem_addr = bus.rd_idx;
        end
    end

    // Arbitration pointer, node counter, sticky overflow and response pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr    <= 1'b0;
            count  <= '0;
            ovf    <= 1'b0;
            vld_p1 <= 1'b0;
            hit_p1 <= 1'b0;
        end else begin
            if (contested) ptr <= ~ptr;
            if (gnt_ld) count <= count + 1'b1;
            if (state == LOADING && bus.ld_valid && full) ovf <= 1'b1;
            vld_p1 <= gnt_rd;
            hit_p1 <= gnt_rd && rd_hit;
        end
    end

    assign bus.ld_ready   = gnt_ld;
    assign bus.rd_gnt     = gnt_rd;
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;

    // Response data comes straight off the RAM's registered output; it is
    // zeroed unless the pending read actually accessed the RAM.
    assign bus.rd_valid   = vld_p1;
    assign bus.rd_err     = vld_p1 && !hit_p1;
    assign bus.rd_x       = hit_p1 ? bus.mem_rdata[2*COORD_W-1:COORD_W] : '0;
    assign bus.rd_y       = hit_p1 ? bus.mem_rdata[COORD_W-1:0]         : '0;

    assign bus.node_count = count;
    assign bus.load_done  = (state == SEALED);
    assign bus.overflow   = ovf;
endmodule

// File: doc/coord_mem_arbiter.md
COORD_MEM_ARBITER -- requirements
Module: coord_mem_arbiter

Interface
REQ-001 Parameter COORD_W, default 16, width of one X or Y coordinate.
REQ-002 Parameter ADDR_W, default 8, node-index width; capacity MAX_NODES = 2**ADDR_W.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ld_valid  in  1  loader presents a coordinate pair.
REQ-006 ld_x, ld_y  in  COORD_W each  coordinate pair to store.
REQ-007 ld_finish  in  1  loader signals the end of initialisation.
REQ-008 ld_ready  out  1  loader write granted this cycle (combinational).
REQ-009 rd_req  in  1  pathfinding engine requests a node.
REQ-010 rd_idx  in  ADDR_W  requested node index.
REQ-011 rd_gnt  out  1  read granted this cycle (combinational).
REQ-012 rd_valid  out  1  read response valid (registered).
REQ-013 rd_x, rd_y  out  COORD_W each  response coordinates (registered).
REQ-014 rd_err  out  1  response is for an index that is not loaded (registered).
REQ-015 mem_en, mem_we  out  1 each  single-port RAM enable and write strobe.
REQ-016 mem_addr  out  ADDR_W  RAM address.
REQ-017 mem_wdata  out  2*COORD_W  RAM write data {x,y}.
REQ-018 mem_rdata  in  2*COORD_W  RAM read data, valid one cycle after mem_en with mem_we=0.
REQ-019 node_count  out  ADDR_W+1  number of stored nodes.
REQ-020 load_done  out  1  table sealed.
REQ-021 overflow  out  1  sticky flag: write attempted while full.

Function
REQ-022 States are LOADING and SEALED. LOADING goes to SEALED at the clock edge on which ld_finish=1. SEALED is held until reset.
REQ-023 The loader is eligible when state=LOADING, ld_valid=1 and node_count<MAX_NODES. The reader is eligible when rd_req=1.
REQ-024 At most one grant per cycle. When only one side is eligible, that side is granted.
REQ-025 When both sides are eligible, the grant goes to the side selected by a 1-bit round-robin pointer. The pointer (reset value: loader) flips to the other side after every contested grant.
REQ-026 On a loader grant:
- mem_en=1, mem_we=1, mem_addr=node_count[ADDR_W-1:0], mem_wdata={ld_x,ld_y}.
- node_count increments by 1 at the next edge.
REQ-027 On a read grant with rd_idx<node_count:
- mem_en=1, mem_we=0, mem_addr=rd_idx.
- Next cycle: rd_valid=1, {rd_x,rd_y}=mem_rdata, rd_err=0.
REQ-028 On a read grant with rd_idx>=node_count:
- No RAM access.
- Next cycle: rd_valid=1, rd_x=rd_y=0, rd_err=1.
REQ-029 rd_valid is a single-cycle pulse per grant. Back-to-back grants produce back-to-back responses in grant order.
REQ-030 When no grant is made, mem_en=0, mem_we=0, and mem_addr/mem_wdata are 0.
REQ-031 ld_valid=1 in LOADING with node_count=MAX_NODES sets overflow at the next edge; ld_ready stays 0. overflow clears only on reset.
REQ-032 ld_valid=1 in SEALED is ignored: ld_ready=0 and overflow is unchanged.
REQ-033 ld_finish asserted in the same cycle as a loader grant: the write completes, node_count increments, and the state becomes SEALED at the same edge.
REQ-034 load_done=1 exactly when state=SEALED.

Reset
REQ-035 While reset=1:
- State is LOADING and the round-robin pointer selects the loader.
- node_count=0; load_done, overflow, rd_valid, rd_err=0; rd_x=rd_y=0.
- ld_ready, rd_gnt, mem_en, mem_we=0.
REQ-036 Reset asserted with a read response pending cancels it: no rd_valid is produced after reset is released.
REQ-037 RAM contents are not cleared by reset; a new load overwrites them starting at address 0.

Verification
REQ-038 Load 3 pairs (1,2), (3,4), (5,6), then ld_finish -> writes to addresses 0,1,2; node_count=3; load_done=1 on the following cycle.
REQ-039 Sealed with 3 nodes, rd_req with rd_idx=1 -> rd_gnt=1, mem_addr=1; next cycle rd_valid=1, rd_x=3, rd_y=4, rd_err=0.
REQ-040 rd_idx=3 with node_count=3 -> no mem_en; next cycle rd_valid=1, rd_err=1, rd_x=rd_y=0.
REQ-041 ld_valid and rd_req held together for 4 cycles from reset -> grants alternate loader, reader, loader, reader.
REQ-042 ADDR_W=2: 5 consecutive writes -> 4 accepted, node_count=4, 5th gets ld_ready=0 and overflow=1.
REQ-043 Reset asserted one cycle after a read grant -> no rd_valid afterwards; node_count=0; overflow=0; load_done=0.
